dram_axi_writer: RTL and testbench

AXI4 write master that turns single-command DRAM write requests from the Cameralink capture path's buffer stage into AXI4 bursts on the PS DDR port. It sits directly downstream of the pixel-buffer gearbox and pulls 512-bit words from that block's async FIFO read port. It drives `dram_write_busy` back to the gearbox to throttle it, and reports completion and error status to software.

---
 rtl/dram_axi_writer_if.sv | 48 ++++
 rtl/dram_axi_writer.sv | 196 +++++++++++++++++++
 tb/tb_dram_axi_writer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_axi_writer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dram_axi_writer_if : AXI4 write-channel bundle (AW, W, B)        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface dram_axi_writer_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/dram_axi_writer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dram_axi_writer : single-command AXI4 INCR burst write master    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dram_axi_writer #(
  parameter int DRAM_ADDR_WIDTH = 48,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int AXI_ID_WIDTH    = 1
) (
  input  logic                       m_axi_aclk,
  input  logic                       reset,
  input  logic                       dram_write_en,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_write_addr,
  input  logic [7:0]                 dram_write_len,
  input  logic [DRAM_DATA_WIDTH-1:0] fifo_dout,
  output logic                       fifo_rd_en,
  output logic                       dram_write_busy,
  dram_axi_writer_if.master          m_axi,
  output logic [31:0]                wr_done_cnt,
  output logic                       bresp_err,
  output logic                       overrun_err,
  output logic                       align_err
);

  localparam int c_addr_lsb = $clog2(DRAM_DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SEND    = 3'd2,
    S_FETCH   = 3'd3,
    S_WAIT_B  = 3'd4
  } state_t;

  state_t                     r_state,      w_state_nxt;
  logic [DRAM_ADDR_WIDTH-1:0] r_awaddr,     w_awaddr_nxt;
  logic [7:0]                 r_awlen,      w_awlen_nxt;
  logic [7:0]                 r_beat,       w_beat_nxt;
  logic [DRAM_DATA_WIDTH-1:0] r_wdata,      w_wdata_nxt;
  logic                       r_awvalid,    w_awvalid_nxt;
  logic                       r_wvalid,     w_wvalid_nxt;
  logic                       r_wlast,      w_wlast_nxt;
  logic                       r_bready,     w_bready_nxt;
  logic                       r_busy,       w_busy_nxt;
  logic                       r_aw_done,    w_aw_done_nxt;
  logic                       r_w_done,     w_w_done_nxt;
  logic [31:0]                r_done_cnt,   w_done_cnt_nxt;
  logic                       r_bresp_err,  w_bresp_err_nxt;
  logic                       r_overrun,    w_overrun_nxt;
  logic                       r_align_err,  w_align_err_nxt;
  logic                       w_rd_pop;
  logic                       w_aw_hs;
  logic                       w_w_hs;
  logic                       w_unused_bid;

  assign w_aw_hs      = r_awvalid & m_axi.awready;
  assign w_w_hs       = r_wvalid & m_axi.wready;
  assign w_unused_bid = ^m_axi.bid;

  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_beat      <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_bready    <= 1'b0;
      r_busy      <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_done_cnt  <= '0;
      r_bresp_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_awlen     <= w_awlen_nxt;
      r_beat      <= w_beat_nxt;
      r_wdata     <= w_wdata_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_wlast     <= w_wlast_nxt;
      r_bready    <= w_bready_nxt;
      r_busy      <= w_busy_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_done_cnt  <= w_done_cnt_nxt;
      r_bresp_err <= w_bresp_err_nxt;
      r_overrun   <= w_overrun_nxt;
      r_align_err <= w_align_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_awaddr_nxt    = r_awaddr;
    w_awlen_nxt     = r_awlen;
    w_beat_nxt      = r_beat;
    w_wdata_nxt     = r_wdata;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_wlast_nxt     = r_wlast;
    w_bready_nxt    = r_bready;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;
    w_done_cnt_nxt  = r_done_cnt;
    w_bresp_err_nxt = r_bresp_err;
    w_overrun_nxt   = r_overrun;
    w_align_err_nxt = r_align_err;
    w_rd_pop        = 1'b0;

    // AW can complete in SEND or FETCH; it is independent of W progress.
    if (w_aw_hs) begin
      w_awvalid_nxt = 1'b0;
      w_aw_done_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (dram_write_en) begin
          w_awaddr_nxt  = {dram_write_addr[DRAM_ADDR_WIDTH-1:c_addr_lsb], {c_addr_lsb{1'b0}}};
          w_awlen_nxt   = dram_write_len;
          w_beat_nxt    = 8'd0;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          if (dram_write_addr[c_addr_lsb-1:0] != '0) w_align_err_nxt = 1'b1;
          w_state_nxt   = S_CAPTURE;
        end
      end
      S_CAPTURE, S_FETCH: begin
        // fifo_dout is valid here: the read strobe fired in the previous cycle.
        w_wdata_nxt  = fifo_dout;
        w_wvalid_nxt = 1'b1;
        w_wlast_nxt  = (r_beat == r_awlen);
        if (r_state == S_CAPTURE) w_awvalid_nxt = 1'b1;
        w_state_nxt  = S_SEND;
      end
      S_SEND: begin
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          if (!r_wlast) begin
            w_rd_pop    = 1'b1;
            w_beat_nxt  = r_beat + 8'd1;
            w_state_nxt = S_FETCH;
          end else begin
            w_w_done_nxt = 1'b1;
          end
        end
        if ((r_aw_done || w_aw_hs) && (r_w_done || (w_w_hs && r_wlast))) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (m_axi.bvalid && r_bready) begin
          w_bready_nxt   = 1'b0;
          w_done_cnt_nxt = r_done_cnt + 32'd1;
          if (m_axi.bresp != 2'b00) w_bresp_err_nxt = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (dram_write_en && r_busy) w_overrun_nxt = 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign fifo_rd_en      = w_rd_pop & ~reset;
  assign dram_write_busy = r_busy;
  assign wr_done_cnt     = r_done_cnt;
  assign bresp_err       = r_bresp_err;
  assign overrun_err     = r_overrun;
  assign align_err       = r_align_err;

  assign m_axi.awid    = {AXI_ID_WIDTH{1'b0}};
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awlen   = r_awlen;
  assign m_axi.awsize  = 3'(c_addr_lsb);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = r_wlast;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_dram_axi_writer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dram_axi_writer : scoreboard bench for dram_axi_writer        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dram_axi_writer;
  localparam int AW  = 48;
  localparam int DW  = 512;
  localparam int IDW = 1;

  logic          m_axi_aclk = 1'b0;
  logic          reset;
  logic          dram_write_en;
  logic [AW-1:0] dram_write_addr;
  logic [7:0]    dram_write_len;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          dram_write_busy;
  logic [31:0]   wr_done_cnt;
  logic          bresp_err, overrun_err, align_err;

  always #5 m_axi_aclk = ~m_axi_aclk;

  dram_axi_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) axi ();

  dram_axi_writer #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)) dut (
    .m_axi_aclk      (m_axi_aclk),
    .reset           (reset),
    .dram_write_en   (dram_write_en),
    .dram_write_addr (dram_write_addr),
    .dram_write_len  (dram_write_len),
    .fifo_dout       (fifo_dout),
    .fifo_rd_en      (fifo_rd_en),
    .dram_write_busy (dram_write_busy),
    .m_axi           (axi),
    .wr_done_cnt     (wr_done_cnt),
    .bresp_err       (bresp_err),
    .overrun_err     (overrun_err),
    .align_err       (align_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_t;

  int checks = 0;
  int errors = 0;

  aw_t           exp_aw_q[$];
  logic [DW:0]   exp_w_q[$];
  logic [1:0]    exp_b_q[$];
  int            exp_pops_q[$];
  logic [1:0]    b_resp_q[$];
  logic [DW-1:0] fifo_q[$];

  int aw_pct = 100, w_pct = 100, b_pct = 100;
  bit aw_force_low = 1'b0;
  int w_stall_beat = -1, w_stall_left = 0;

  int aw_cnt, wl_cnt, b_hs_cnt, w_beat_idx, pops, b_issued;
  logic [31:0] model_cnt;
  logic model_berr;
  bit model_align = 1'b0, model_ovr = 1'b0;
  int n_cmds = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Async-FIFO read port model: word appears the cycle after any strobe.
  always @(posedge m_axi_aclk) begin
    if (dram_write_en || fifo_rd_en) begin
      if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      else fifo_dout <= '0;
    end
  end

  // AW/W ready drivers
  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    forever begin
      @(posedge m_axi_aclk); #1;
      axi.awready = !aw_force_low && ($urandom_range(99, 0) < aw_pct);
      if (axi.wvalid && w_beat_idx == w_stall_beat && w_stall_left > 0) begin
        axi.wready = 1'b0;
        w_stall_left--;
      end else begin
        axi.wready = ($urandom_range(99, 0) < w_pct);
      end
    end
  end

  // B responder: answers only once both AW and last W of a burst are seen
  initial begin
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    axi.bid    = '0;
    b_issued   = 0;
    forever begin
      @(posedge m_axi_aclk); #1;
      if (reset) begin
        axi.bvalid = 1'b0;
        b_issued   = 0;
      end else begin
        if (axi.bvalid && b_hs_cnt == b_issued) axi.bvalid = 1'b0;
        if (!axi.bvalid && aw_cnt > b_issued && wl_cnt > b_issued &&
            $urandom_range(99, 0) < b_pct) begin
          axi.bvalid = 1'b1;
          if (b_resp_q.size() > 0) axi.bresp = b_resp_q.pop_front();
          else axi.bresp = 2'b00;
          b_issued++;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    aw_t a;
    logic [DW:0] w;
    logic [1:0] eb;
    int ep;
    bit post_b, prev_aw_stall, prev_w_stall, prev_bready;
    logic [AW-1:0] prev_awaddr;
    logic [7:0] prev_awlen;
    logic [DW-1:0] prev_wdata;
    post_b = 0; prev_aw_stall = 0; prev_w_stall = 0; prev_bready = 0;
    aw_cnt = 0; wl_cnt = 0; b_hs_cnt = 0; w_beat_idx = 0; pops = 0;
    model_cnt = 0; model_berr = 0;
    forever begin
      @(negedge m_axi_aclk);
      if (reset) begin
        post_b = 0; prev_aw_stall = 0; prev_w_stall = 0; prev_bready = 0;
        aw_cnt = 0; wl_cnt = 0; b_hs_cnt = 0; w_beat_idx = 0; pops = 0;
        model_cnt = 0; model_berr = 0;
      end else begin
        if (post_b) begin
          chk("wr_done_cnt", wr_done_cnt, model_cnt);
          chk("bresp_err", bresp_err, model_berr);
          chk("busy_after_b", dram_write_busy, 0);
          post_b = 0;
        end
        if (prev_aw_stall)
          chk("aw_stable", {axi.awvalid, axi.awaddr, axi.awlen}, {1'b1, prev_awaddr, prev_awlen});
        if (prev_w_stall) begin
          chk("w_stable_data", axi.wdata, prev_wdata);
          chk("w_stable_valid", axi.wvalid, 1);
        end
        if (axi.bready && !prev_bready)
          chk("bready_after_aw_w", (aw_cnt > b_hs_cnt) && (wl_cnt > b_hs_cnt), 1);
        prev_bready = axi.bready;
        if (fifo_rd_en) pops++;
        if (axi.awvalid && axi.awready) begin
          if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            a = exp_aw_q.pop_front();
            chk("awaddr", axi.awaddr, a.addr);
            chk("awlen", axi.awlen, a.len);
          end
          chk("aw_const", {axi.awid, axi.awsize, axi.awburst, axi.awcache, axi.awprot},
              {1'b0, 3'd6, 2'b01, 4'b0011, 3'b000});
          aw_cnt++;
        end
        if (axi.wvalid && axi.wready) begin
          if (exp_w_q.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            w = exp_w_q.pop_front();
            chk("wdata", axi.wdata, w[DW-1:0]);
            chk("wlast", axi.wlast, w[DW]);
          end
          chk("wstrb", axi.wstrb, {(DW/8){1'b1}});
          w_beat_idx++;
          if (axi.wlast) begin
            wl_cnt++;
            w_beat_idx = 0;
          end
        end
        if (axi.bvalid && axi.bready) begin
          if (exp_b_q.size() == 0) chk("b_unexpected", 1, 0);
          else begin
            eb = exp_b_q.pop_front();
            ep = exp_pops_q.pop_front();
            chk("fifo_rd_en_pulses", pops, ep);
            if (eb != 2'b00) model_berr = 1'b1;
          end
          pops = 0;
          model_cnt = model_cnt + 32'd1;
          b_hs_cnt++;
          post_b = 1;
        end
        prev_aw_stall = axi.awvalid && !axi.awready;
        prev_awaddr   = axi.awaddr;
        prev_awlen    = axi.awlen;
        prev_w_stall  = axi.wvalid && !axi.wready;
        prev_wdata    = axi.wdata;
      end
    end
  end

  task automatic issue(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] resp,
                       input logic [DW-1:0] base, input bit rand_data);
    aw_t a;
    logic [DW-1:0] w;
    a.addr = addr & ~48'h3F;
    a.len  = len;
    exp_aw_q.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      w = rand_data ? rnd_word() : base + DW'(i);
      fifo_q.push_back(w);
      exp_w_q.push_back({(i == int'(len)), w});
    end
    exp_b_q.push_back(resp);
    b_resp_q.push_back(resp);
    exp_pops_q.push_back(int'(len));
    if (addr[5:0] != 6'd0) model_align = 1'b1;
    n_cmds++;
    dram_write_en   = 1'b1;
    dram_write_addr = addr;
    dram_write_len  = len;
    @(posedge m_axi_aclk); #1;
    dram_write_en   = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge m_axi_aclk); #1;
      if (!dram_write_busy && exp_b_q.size() == 0) ok = 1;
    end
    if (!ok) chk("done_timeout", 0, 1);
    @(negedge m_axi_aclk); #1;
    chk("align_err", align_err, model_align);
    chk("overrun_err", overrun_err, model_ovr);
    chk("aw_issued", aw_cnt, n_cmds);
  endtask

  initial begin : stim
    logic [AW-1:0] ra;
    bit got;
    reset = 1'b1;
    dram_write_en = 1'b0;
    dram_write_addr = '0;
    dram_write_len = '0;
    repeat (3) @(posedge m_axi_aclk);
    #1;
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, fifo_rd_en, dram_write_busy}, 0);
    chk("rst_awaddr_awlen", {axi.awaddr, axi.awlen}, 0);
    chk("rst_wdata", axi.wdata, 0);
    chk("rst_status", {wr_done_cnt, bresp_err, overrun_err, align_err}, 0);
    reset = 1'b0;
    @(posedge m_axi_aclk); #1;

    // Single beat, all ready: exact cycle timing
    issue(48'h4_0000_0000, 8'd0, 2'b00, {64{8'hA5}}, 0);
    chk("busy_T1", {dram_write_busy, axi.awvalid}, 2'b10);
    @(posedge m_axi_aclk); #1;
    chk("valids_T2", {axi.awvalid, axi.wvalid, axi.wlast, dram_write_busy}, 4'b1111);
    @(posedge m_axi_aclk); #1;
    chk("bready_T3", {axi.bready, dram_write_busy}, 2'b11);
    @(posedge m_axi_aclk); #1;
    chk("idle_T4", {dram_write_busy, axi.bready}, 2'b00);
    chk("cnt_T4", wr_done_cnt, 1);
    wait_done();

    // 4-beat burst, beat 2 stalled two cycles
    w_stall_beat = 1;
    w_stall_left = 2;
    issue(48'h4_0000_1000, 8'd3, 2'b00, 512'd1, 0);
    wait_done();
    chk("stall_consumed", w_stall_left, 0);
    w_stall_beat = -1;

    // AW held off until 5 cycles past the last W handshake
    aw_force_low = 1'b1;
    issue(48'h4_0000_2000, 8'd1, 2'b00, '0, 1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge m_axi_aclk); #1;
      if (wl_cnt == n_cmds) got = 1;
    end
    chk("w_done_before_aw", got, 1);
    repeat (5) @(posedge m_axi_aclk);
    #1;
    chk("held_no_bready", {axi.bready, axi.awvalid, dram_write_busy}, 3'b011);
    aw_force_low = 1'b0;
    wait_done();

    // SLVERR, then a good burst: bresp_err must stay set
    issue(48'h4_0000_3000, 8'd2, 2'b10, '0, 1);
    wait_done();
    issue(48'h4_0000_4000, 8'd0, 2'b00, '0, 1);
    wait_done();

    // Misaligned address
    issue(48'h4_0000_0010, 8'd0, 2'b00, '0, 1);
    wait_done();

    // Command while busy is dropped but its FIFO pop still happens
    aw_force_low = 1'b1;
    issue(48'h4_0000_5000, 8'd0, 2'b00, '0, 1);
    fifo_q.push_back(rnd_word());
    repeat (2) @(posedge m_axi_aclk);
    #1;
    dram_write_en = 1'b1;
    dram_write_addr = 48'h4_0000_6000;
    model_ovr = 1'b1;
    @(posedge m_axi_aclk); #1;
    dram_write_en = 1'b0;
    aw_force_low = 1'b0;
    wait_done();
    repeat (10) @(posedge m_axi_aclk);
    #1;
    chk("single_aw_after_overrun", aw_cnt, n_cmds);

    // Randomized bursts
    for (int n = 0; n < 25; n++) begin
      aw_pct = $urandom_range(100, 30);
      w_pct  = $urandom_range(100, 30);
      b_pct  = $urandom_range(100, 30);
      ra = {$urandom, $urandom};
      if ($urandom_range(3, 0) != 0) ra[5:0] = 6'd0;
      issue(ra, 8'($urandom_range(7, 0)), ($urandom_range(7, 0) == 0) ? 2'b10 : 2'b00, '0, 1);
      wait_done();
    end

    // Reset mid-burst with wvalid held high
    aw_pct = 100; w_pct = 0; b_pct = 100;
    issue(48'h4_0000_7000, 8'd2, 2'b00, '0, 1);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge m_axi_aclk); #1;
      if (axi.wvalid) got = 1;
    end
    chk("wvalid_before_reset", got, 1);
    reset = 1'b1;
    @(posedge m_axi_aclk); #1;
    chk("reset_mid_valids", {axi.awvalid, axi.wvalid, axi.bready, dram_write_busy, fifo_rd_en}, 0);
    chk("reset_mid_cnt", wr_done_cnt, 0);
    reset = 1'b0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_b_q.delete();
    exp_pops_q.delete(); b_resp_q.delete(); fifo_q.delete();
    model_align = 1'b0; model_ovr = 1'b0; n_cmds = 0;
    w_pct = 100;
    @(posedge m_axi_aclk); #1;
    issue(48'h4_0000_8000, 8'd1, 2'b00, '0, 1);
    wait_done();
    chk("fresh_cnt", wr_done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
`default_nettype wire
